// File: rtl/imm_gen_pkg.sv
// Shared constants for the immediate generator: format codes, opcodes and the
// shift funct3 encodings. Imported by imm_decode and imm_gen_pipe.
// Optional feature macro used by the design: IMM_ILLEGAL_EN.
package imm_gen_pkg;

    localparam int unsigned FMT_W   = 3;
    localparam int unsigned INSTR_W = 32;

    // Immediate format codes reported on out_fmt
    localparam logic [FMT_W-1:0] FMT_NONE  = 3'd0;
    localparam logic [FMT_W-1:0] FMT_I     = 3'd1;
    localparam logic [FMT_W-1:0] FMT_S     = 3'd2;
    localparam logic [FMT_W-1:0] FMT_B     = 3'd3;
    localparam logic [FMT_W-1:0] FMT_U     = 3'd4;
    localparam logic [FMT_W-1:0] FMT_J     = 3'd5;
    localparam logic [FMT_W-1:0] FMT_SHAMT = 3'd6;

    // Major opcodes (instr[6:0]) that carry an immediate
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

    localparam logic [2:0] FUNCT3_SLL = 3'b001;
    localparam logic [2:0] FUNCT3_SRL = 3'b101;

    // funct3 selects a shift (SLLI / SRLI / SRAI) inside OP-IMM(-32)
    function automatic logic is_shift(input logic [2:0] funct3);
        return (funct3 == FUNCT3_SLL) || (funct3 == FUNCT3_SRL);
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Push/pop bus of the immediate generator.
//   in_*  : producer side (instruction + tag with valid/ready)
//   out_* : consumer side (head entry with valid/ready)
// master = environment driving instructions and consuming results,
// slave  = imm_gen_pipe. out_illegal exists only with IMM_ILLEGAL_EN.
interface imm_gen_pipe_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_imm;
    logic [2:0]        out_fmt;
    logic [TAG_W-1:0]  out_tag;
`ifdef IMM_ILLEGAL_EN
    logic              out_illegal;
`endif

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_tag
`ifdef IMM_ILLEGAL_EN
        , input out_illegal
`endif
    );

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_tag
`ifdef IMM_ILLEGAL_EN
        , output out_illegal
`endif
    );

endinterface

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate decoder.
//   instr_i   : raw 32-bit instruction
//   imm_c     : immediate extended to XLEN (0 when no format applies)
//   fmt_c     : format code (FMT_*)
//   illegal_c : opcode not in the decode table (only with IMM_ILLEGAL_EN)
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [INSTR_W-1:0] instr_i,
    output logic [XLEN-1:0]    imm_c,
    output logic [FMT_W-1:0]   fmt_c
`ifdef IMM_ILLEGAL_EN
    , output logic             illegal_c
`endif
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_sh;
    logic [XLEN-1:0] imm_shw;

    // Candidate immediates for every format; signed size casts sign-extend
    always_comb begin
        opcode  = instr_i[6:0];
        funct3  = instr_i[14:12];
        imm_i   = XLEN'($signed(instr_i[31:20]));
        imm_s   = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
        imm_b   = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                 instr_i[11:8], 1'b0}));
        imm_u   = XLEN'($signed({instr_i[31:12], 12'b0}));
        imm_j   = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                 instr_i[30:21], 1'b0}));
        // 6-bit shamt on RV64, 5-bit on RV32; word shifts always 5-bit
        if (XLEN == 64) begin
            imm_sh = XLEN'(instr_i[25:20]);
        end else begin
            imm_sh = XLEN'(instr_i[24:20]);
        end
        imm_shw = XLEN'(instr_i[24:20]);
    end

    // Opcode table -> selected format and immediate
    always_comb begin
        imm_c = '0;
        fmt_c = FMT_NONE;
        unique case (opcode)
            OPC_LOAD, OPC_JALR: begin
                imm_c = imm_i;
                fmt_c = FMT_I;
            end
            OPC_OP_IMM: begin
                if (is_shift(funct3)) begin
                    imm_c = imm_sh;
                    fmt_c = FMT_SHAMT;
                end else begin
                    imm_c = imm_i;
                    fmt_c = FMT_I;
                end
            end
            OPC_OP_IMM_32: begin
                // Word ops exist only on RV64
                if (XLEN == 64) begin
                    if (is_shift(funct3)) begin
                        imm_c = imm_shw;
                        fmt_c = FMT_SHAMT;
                    end else begin
                        imm_c = imm_i;
                        fmt_c = FMT_I;
                    end
                end
            end
            OPC_STORE: begin
                imm_c = imm_s;
                fmt_c = FMT_S;
            end
            OPC_BRANCH: begin
                imm_c = imm_b;
                fmt_c = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_c = imm_u;
                fmt_c = FMT_U;
            end
            OPC_JAL: begin
                imm_c = imm_j;
                fmt_c = FMT_J;
            end
            default: begin
                imm_c = '0;
                fmt_c = FMT_NONE;
            end
        endcase
    end

`ifdef IMM_ILLEGAL_EN
    // Every table opcode ends in 2'b11, so any non-32-bit encoding also lands on NONE
    always_comb begin
        illegal_c = (instr_i[1:0] != 2'b11) || (fmt_c == FMT_NONE);
    end
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered, back-pressured immediate generator for the decode stage.
// Decodes the immediate of each pushed instruction and queues it with its
// tag in a DEPTH-entry FIFO; flush squashes all queued entries.
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   flush    : synchronous squash (same-cycle push and pop discarded)
//   bus      : imm_gen_pipe_if.slave (in_* push side, out_* head entry)
// Optional feature: define IMM_ILLEGAL_EN to store and report out_illegal.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [XLEN-1:0]  imm_mem_q [DEPTH];
    logic [FMT_W-1:0] fmt_mem_q [DEPTH];
    logic [TAG_W-1:0] tag_mem_q [DEPTH];

    logic [XLEN-1:0]  dec_imm;
    logic [FMT_W-1:0] dec_fmt;
    logic             push_c;
    logic             pop_c;

`ifdef IMM_ILLEGAL_EN
    logic             ill_mem_q [DEPTH];
    logic             dec_ill;
`endif

    // Decode on the push side so the FIFO holds finished results
    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr_i   (bus.in_instr),
        .imm_c     (dec_imm),
        .fmt_c     (dec_fmt)
`ifdef IMM_ILLEGAL_EN
        , .illegal_c (dec_ill)
`endif
    );

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign push_c = bus.in_valid & in_ready_q;
    assign pop_c  = out_valid_q & bus.out_ready;

    // Pointer / occupancy next state; ready and valid are registered from count_d
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop_c) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push_c && !pop_c) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_c && !push_c) begin
                count_d = count_q - CNT_W'(1);
            end
        end
        in_ready_d  = (count_d != CNT_W'(DEPTH));
        out_valid_d = (count_d != '0);
    end

    // Control registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Entry storage; cleared on reset so the head reads zero / NONE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                imm_mem_q[i] <= '0;
                fmt_mem_q[i] <= FMT_NONE;
                tag_mem_q[i] <= '0;
`ifdef IMM_ILLEGAL_EN
                ill_mem_q[i] <= 1'b0;
`endif
            end
        end else if (push_c && !flush) begin
            imm_mem_q[wr_ptr_q] <= dec_imm;
            fmt_mem_q[wr_ptr_q] <= dec_fmt;
            tag_mem_q[wr_ptr_q] <= bus.in_tag;
`ifdef IMM_ILLEGAL_EN
            ill_mem_q[wr_ptr_q] <= dec_ill;
`endif
        end
    end

    // Head entry straight from storage: stable while stalled
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_imm   = imm_mem_q[rd_ptr_q];
    assign bus.out_fmt   = fmt_mem_q[rd_ptr_q];
    assign bus.out_tag   = tag_mem_q[rd_ptr_q];
`ifdef IMM_ILLEGAL_EN
    assign bus.out_illegal = ill_mem_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe (XLEN=64, DEPTH=2, TAG_W=8).
module tb_imm_gen_pipe;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned TAG_W = 8;

    logic clk;
    logic reset_n;
    logic flush;

    int n_tests;
    int n_fail;

    imm_gen_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    imm_gen_pipe #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one instruction into an empty FIFO, check the head, then let it drain
    task automatic push_one(input string name, input logic [31:0] instr,
                            input logic [7:0] tag, input logic [63:0] eimm,
                            input logic [2:0] efmt);
        bus.in_valid  = 1'b1;
        bus.in_instr  = instr;
        bus.in_tag    = tag;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({name, "_imm"},   bus.out_imm,        eimm);
        check({name, "_fmt"},   64'(bus.out_fmt),   64'(efmt));
        check({name, "_tag"},   64'(bus.out_tag),   64'(tag));
`ifdef IMM_ILLEGAL_EN
        check({name, "_illegal"}, 64'(bus.out_illegal), 64'(efmt == 3'd0));
`endif
        step();
        check({name, "_drained"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset_n       = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        // Reset state
        step();
        step();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_imm",   bus.out_imm,        64'd0);
        check("rst_out_fmt",   64'(bus.out_fmt),   64'd0);
        check("rst_out_tag",   64'(bus.out_tag),   64'd0);
        reset_n = 1'b1;
        step();

        // Decode vectors, fmt: 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 0 NONE
        push_one("addi_m1",   32'hFFF00093, 8'h01, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1);
        push_one("sw_m4",     32'hFE112E23, 8'h02, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2);
        push_one("beq_m8",    32'hFE000CE3, 8'h03, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3);
        push_one("lui_neg",   32'h800000B7, 8'h04, 64'hFFFF_FFFF_8000_0000, 3'd4);
        push_one("slli_63",   32'h03F09093, 8'h05, 64'd63,                  3'd6);
        push_one("jal_8",     32'h0080006F, 8'h06, 64'd8,                   3'd5);
        push_one("lw_2047",   32'h7FF02083, 8'h07, 64'd2047,                3'd1);
        push_one("auipc_1",   32'h00001017, 8'h08, 64'h1000,                3'd4);
        push_one("srliw_31",  32'h01F0509B, 8'h09, 64'd31,                  3'd6);
        push_one("addiw_m1",  32'hFFF0009B, 8'h0A, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1);
        push_one("unknown",   32'hFFFFFFFF, 8'h0B, 64'd0,                   3'd0);
        push_one("zero_word", 32'h00000000, 8'h0C, 64'd0,                   3'd0);

        // Back-pressure and FIFO ordering with pointer wrap
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'hFFF00093;
        bus.in_tag    = 8'd1;
        step();
        check("ord_ready_after1", 64'(bus.in_ready), 64'd1);
        check("ord_head1",        64'(bus.out_tag),  64'd1);
        bus.in_tag = 8'd2;
        step();
        check("ord_ready_full",   64'(bus.in_ready), 64'd0);
        check("ord_head1_hold",   64'(bus.out_tag),  64'd1);
        bus.in_tag = 8'd3;
        step();
        check("ord_ready_stall",  64'(bus.in_ready), 64'd0);
        check("ord_head1_stall",  64'(bus.out_tag),  64'd1);
        bus.out_ready = 1'b1;
        step();
        check("ord_head2",        64'(bus.out_tag),  64'd2);
        check("ord_ready_pop",    64'(bus.in_ready), 64'd1);
        step();
        check("ord_head3",        64'(bus.out_tag),  64'd3);
        check("ord_valid_pp",     64'(bus.out_valid), 64'd1);
        check("ord_ready_pp",     64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b0;
        step();
        check("ord_empty",        64'(bus.out_valid), 64'd0);

        // Flush with a full FIFO
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_tag    = 8'h10;
        step();
        bus.in_tag    = 8'h11;
        step();
        check("fl_full", 64'(bus.in_ready), 64'd0);
        flush        = 1'b1;
        bus.in_instr = 32'h800000B7;
        bus.in_tag   = 8'h22;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_valid", 64'(bus.out_valid), 64'd0);
        check("fl_ready", 64'(bus.in_ready),  64'd1);

        // Flush with one entry while a push and pop are both offered
        bus.in_valid = 1'b1;
        bus.in_tag   = 8'h30;
        step();
        flush         = 1'b1;
        bus.in_tag    = 8'h44;
        bus.out_ready = 1'b1;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("fl2_valid",      64'(bus.out_valid), 64'd0);
        step();
        check("fl2_stay_empty", 64'(bus.out_valid), 64'd0);
        push_one("post_flush", 32'h00001017, 8'h55, 64'h1000, 3'd4);

        // Asynchronous reset with two entries queued
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'hFFF00093;
        bus.in_tag    = 8'h60;
        step();
        bus.in_tag    = 8'h61;
        step();
        bus.in_valid = 1'b0;
        check("ar_full", 64'(bus.in_ready), 64'd0);
        reset_n = 1'b0;
        #1;
        check("ar_valid", 64'(bus.out_valid), 64'd0);
        check("ar_imm",   bus.out_imm,        64'd0);
        check("ar_ready", 64'(bus.in_ready),  64'd1);
        step();
        reset_n = 1'b1;
        step();
        check("ar_still_empty", 64'(bus.out_valid), 64'd0);
        push_one("post_reset", 32'hFE112E23, 8'h77, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
